// File: rtl/debug_frame_sender_pkg.sv
// Shared debug definitions: frame marker, sender FSM states, snapshot size.
package debug_frame_sender_pkg;

    localparam logic [7:0]  FRAME_SOF     = 8'hA5;
    localparam int unsigned DBG_NUM_WORDS = 16;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned BYTE_W        = 8;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        COUNT,
        LOAD,
        WORD,
        CHK,
        DONE
    } state_e;

    // MSB-first byte select from a latched snapshot word.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                    input logic [1:0]        idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/debug_frame_sender_if.sv
// Snapshot-mux / UART-FIFO side signals of the debug frame sender.
interface debug_frame_sender_if
    import debug_frame_sender_pkg::*;
#(
    parameter int unsigned IDX_W = 4
);
    logic                start;
    logic                fifoFull;
    logic [WORD_W-1:0]   wordData;
    logic [IDX_W-1:0]    wordIndex;
    logic [BYTE_W-1:0]   dataToUartOutFifo;
    logic                writeFifoFlag;
    logic                pipeFreeze;
    logic                busy;
    logic                done;

    modport master (
        input  start, fifoFull, wordData,
        output wordIndex, dataToUartOutFifo, writeFifoFlag, pipeFreeze, busy, done
    );

    modport slave (
        output start, fifoFull, wordData,
        input  wordIndex, dataToUartOutFifo, writeFifoFlag, pipeFreeze, busy, done
    );
endinterface

// File: rtl/debug_frame_sender.sv
// Serializes a frozen pipeline snapshot into SOF/count/payload/XOR-checksum bytes.
module debug_frame_sender
    import debug_frame_sender_pkg::*;
#(
    parameter int unsigned NUM_WORDS = DBG_NUM_WORDS,
    parameter logic [7:0]  SOF_BYTE  = FRAME_SOF,
    parameter int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input logic                  clock,
    input logic                  reset,
    debug_frame_sender_if.master bus
);

    localparam logic [BYTE_W-1:0] COUNT_BYTE = BYTE_W'(NUM_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_WORDS - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    word_idx_q, word_idx_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0]   word_reg_q, word_reg_d;
    logic [BYTE_W-1:0]   chk_q, chk_d;
    logic                pipe_freeze_q, pipe_freeze_d;
    logic                emit_c;
    logic                write_c;
    logic [BYTE_W-1:0]   byte_c;

    // Byte-emitting states strobe whenever the FIFO can take a byte.
    always_comb begin
        emit_c  = (state_q == SOF) || (state_q == COUNT) ||
                  (state_q == WORD) || (state_q == CHK);
        write_c = emit_c && !bus.fifoFull;
    end

    // Byte presented to the FIFO for the current state; zero when not emitting.
    always_comb begin
        byte_c = '0;
        case (state_q)
            SOF:     byte_c = SOF_BYTE;
            COUNT:   byte_c = COUNT_BYTE;
            WORD:    byte_c = word_byte(word_reg_q, byte_idx_q);
            CHK:     byte_c = chk_q;
            default: byte_c = '0;
        endcase
    end

    // Next-state, index, word latch and checksum update; everything holds on backpressure.
    always_comb begin
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        byte_idx_d    = byte_idx_q;
        word_reg_d    = word_reg_q;
        chk_d         = chk_q;
        pipe_freeze_d = pipe_freeze_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d       = SOF;
                    word_idx_d    = '0;
                    byte_idx_d    = '0;
                    chk_d         = '0;
                    pipe_freeze_d = 1'b1;
                end
            end
            SOF: begin
                if (write_c) state_d = COUNT;
            end
            COUNT: begin
                if (write_c) begin
                    chk_d   = chk_q ^ byte_c;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                word_reg_d = bus.wordData;
                byte_idx_d = '0;
                state_d    = WORD;
            end
            WORD: begin
                if (write_c) begin
                    chk_d = chk_q ^ byte_c;
                    if (byte_idx_q == 2'd3) begin
                        if (word_idx_q == LAST_IDX) begin
                            state_d = CHK;
                        end else begin
                            word_idx_d = word_idx_q + IDX_W'(1);
                            state_d    = LOAD;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            CHK: begin
                if (write_c) begin
                    state_d       = DONE;
                    pipe_freeze_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d       = IDLE;
                pipe_freeze_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            word_idx_q    <= '0;
            byte_idx_q    <= '0;
            word_reg_q    <= '0;
            chk_q         <= '0;
            pipe_freeze_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_idx_q    <= word_idx_d;
            byte_idx_q    <= byte_idx_d;
            word_reg_q    <= word_reg_d;
            chk_q         <= chk_d;
            pipe_freeze_q <= pipe_freeze_d;
        end
    end

    assign bus.wordIndex         = word_idx_q;
    assign bus.dataToUartOutFifo = byte_c;
    assign bus.writeFifoFlag     = write_c;
    assign bus.pipeFreeze        = pipe_freeze_q;
    assign bus.busy              = (state_q != IDLE);
    assign bus.done              = (state_q == DONE);

endmodule

// File: tb/tb_debug_frame_sender.sv
// Directed bench for debug_frame_sender (NUM_WORDS=2 and NUM_WORDS=1 instances).
module tb_debug_frame_sender;

    logic clock = 1'b0;
    logic reset;
    logic corrupt;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   start_cyc;
    int   base;
    int   rel;
    int   d0;
    int   p0;
    int   done2_cnt = 0;
    int   done1_cnt = 0;
    int   pf2_cnt = 0;
    logic [7:0] cap2 [$];
    logic [7:0] cap1 [$];

    logic [7:0] exp2 [11] = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                              8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h64};
    logic [7:0] exp1 [7]  = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};

    debug_frame_sender_if #(.IDX_W(1)) b2 ();
    debug_frame_sender_if #(.IDX_W(1)) b1 ();

    debug_frame_sender #(.NUM_WORDS(2)) dut2 (.clock(clock), .reset(reset), .bus(b2.master));
    debug_frame_sender #(.NUM_WORDS(1)) dut1 (.clock(clock), .reset(reset), .bus(b1.master));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Upstream snapshot mux models; corrupt overrides after the word is latched.
    assign b2.wordData = corrupt ? 32'hCAFEF00D :
                         ((b2.wordIndex == 1'b0) ? 32'h11223344 : 32'hDEADBEEF);
    assign b1.wordData = 32'h00000000;

    // FIFO-side monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (b2.writeFifoFlag) cap2.push_back(b2.dataToUartOutFifo);
        if (b1.writeFifoFlag) cap1.push_back(b1.dataToUartOutFifo);
        if (b2.done) done2_cnt <= done2_cnt + 1;
        if (b1.done) done1_cnt <= done1_cnt + 1;
        if (b2.pipeFreeze) pf2_cnt <= pf2_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int sel, input int budget, output int r);
        r = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((sel == 2 && b2.done) || (sel == 1 && b1.done)) begin
                r = cyc - start_cyc;
                break;
            end
        end
    endtask

    task automatic check_frame(input int sel, input int b, input string tag);
        logic [7:0] obs;
        int n;
        n = (sel == 2) ? 11 : 7;
        chk({tag, "_len"}, 32'((sel == 2 ? cap2.size() : cap1.size()) - b), 32'(n));
        for (int i = 0; i < n; i++) begin
            obs = 8'hxx;
            if (sel == 2 && b + i < cap2.size()) obs = cap2[b + i];
            if (sel == 1 && b + i < cap1.size()) obs = cap1[b + i];
            chk($sformatf("%s_byte%0d", tag, i), 32'(obs),
                32'(sel == 2 ? exp2[i] : exp1[i]));
        end
    endtask

    task automatic start2;
        b2.start  = 1'b1;
        start_cyc = cyc;
        base      = cap2.size();
        tick();
        b2.start  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        corrupt = 1'b0;
        b2.start = 1'b0; b2.fifoFull = 1'b0;
        b1.start = 1'b0; b1.fifoFull = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_index", 32'(b2.wordIndex), 32'd0);
        chk("rst_data", 32'(b2.dataToUartOutFifo), 32'd0);
        chk("rst_wr", 32'(b2.writeFifoFlag), 32'd0);
        chk("rst_freeze", 32'(b2.pipeFreeze), 32'd0);
        chk("rst_busy", 32'(b2.busy), 32'd0);
        chk("rst_done", 32'(b2.done), 32'd0);
        chk("rst1_busy", 32'(b1.busy), 32'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Basic frame with cycle-by-cycle control checks
        d0 = done2_cnt; p0 = pf2_cnt;
        b2.start = 1'b1; start_cyc = cyc; base = cap2.size();
        chk("c0_busy", 32'(b2.busy), 32'd0);
        for (int c = 1; c <= 14; c++) begin
            tick();
            b2.start = 1'b0;
            chk($sformatf("c%0d_cycle", c), 32'(cyc - start_cyc), 32'(c));
            chk($sformatf("c%0d_busy", c), 32'(b2.busy), 32'd1);
            chk($sformatf("c%0d_freeze", c), 32'(b2.pipeFreeze), 32'(c <= 13));
            chk($sformatf("c%0d_done", c), 32'(b2.done), 32'(c == 14));
            chk($sformatf("c%0d_index", c), 32'(b2.wordIndex), 32'(c >= 8));
        end
        chk("c1_sof_wr", 32'(1), 32'(1));
        tick();
        chk("post_busy", 32'(b2.busy), 32'd0);
        chk("post_done", 32'(b2.done), 32'd0);
        chk("post_data", 32'(b2.dataToUartOutFifo), 32'd0);
        check_frame(2, base, "basic");
        chk("basic_freeze_cycles", 32'(pf2_cnt - p0), 32'd13);
        chk("basic_done_pulses", 32'(done2_cnt - d0), 32'd1);

        // Backpressure on byte 0x44 for three cycles
        start2();
        repeat (6) tick();
        b2.fifoFull = 1'b1;
        #1;
        for (int h = 0; h < 3; h++) begin
            if (h > 0) tick();
            chk($sformatf("bp_hold%0d_wr", h), 32'(b2.writeFifoFlag), 32'd0);
            chk($sformatf("bp_hold%0d_data", h), 32'(b2.dataToUartOutFifo), 32'h44);
        end
        tick();
        b2.fifoFull = 1'b0;
        #1;
        chk("bp_resume_wr", 32'(b2.writeFifoFlag), 32'd1);
        chk("bp_resume_data", 32'(b2.dataToUartOutFifo), 32'h44);
        wait_done(2, 40, rel);
        chk("bp_done_cycle", 32'(rel), 32'd17);
        tick();
        check_frame(2, base, "bp");

        // Upstream word changes after it has been latched
        start2();
        repeat (3) tick();
        corrupt = 1'b1;
        repeat (4) tick();
        corrupt = 1'b0;
        wait_done(2, 40, rel);
        chk("latch_done_cycle", 32'(rel), 32'd14);
        tick();
        check_frame(2, base, "latch");

        // Repeated start while busy, then a start right after done
        d0 = done2_cnt;
        start2();
        rel = -1;
        for (int i = 0; i < 40; i++) begin
            b2.start = ~b2.start;
            tick();
            if (b2.done) begin
                rel = cyc - start_cyc;
                break;
            end
        end
        chk("rep_done_cycle", 32'(rel), 32'd14);
        b2.start = 1'b1;
        tick();
        chk("rep_idle_after_done", 32'(b2.busy), 32'd0);
        chk("rep_one_frame_pulses", 32'(done2_cnt - d0), 32'd1);
        check_frame(2, base, "rep_a");
        start2();
        chk("rep_b_accepted", 32'(b2.busy), 32'd1);
        wait_done(2, 40, rel);
        chk("rep_b_done_cycle", 32'(rel), 32'd14);
        tick();
        check_frame(2, base, "rep_b");

        // Reset asserted during the last byte of word 0
        d0 = done2_cnt;
        start2();
        repeat (6) tick();
        reset = 1'b0;
        #1;
        chk("abort_index", 32'(b2.wordIndex), 32'd0);
        chk("abort_data", 32'(b2.dataToUartOutFifo), 32'd0);
        chk("abort_wr", 32'(b2.writeFifoFlag), 32'd0);
        chk("abort_freeze", 32'(b2.pipeFreeze), 32'd0);
        chk("abort_busy", 32'(b2.busy), 32'd0);
        chk("abort_done", 32'(b2.done), 32'd0);
        repeat (2) tick();
        chk("abort_bytes", 32'(cap2.size() - base), 32'd5);
        reset = 1'b1;
        tick();
        chk("abort_no_done", 32'(done2_cnt - d0), 32'd0);
        start2();
        wait_done(2, 40, rel);
        chk("abort_fresh_done_cycle", 32'(rel), 32'd14);
        tick();
        check_frame(2, base, "abort_fresh");

        // Single-word frame
        b1.start  = 1'b1;
        start_cyc = cyc;
        base      = cap1.size();
        tick();
        b1.start  = 1'b0;
        wait_done(1, 30, rel);
        chk("one_done_cycle", 32'(rel), 32'd9);
        tick();
        check_frame(1, base, "one");
        chk("one_busy_after", 32'(b1.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_frame_sender.md
# debug_frame_sender

Serializes a frozen snapshot of the pipeline latches into a framed byte stream for the UART transmit FIFO. Sits between the pipeline-register snapshot mux (upstream, indexed by word number) and the UART transmit FIFO write port (downstream). Holds the pipeline frozen for the whole frame, paces itself against FIFO-full backpressure, and appends an XOR checksum.

## Interface
- NUM_WORDS, 16: number of 32-bit snapshot words per frame. Legal range 1..255.
- SOF_BYTE, 8'hA5: start-of-frame marker byte.
- IDX_W, $clog2(NUM_WORDS) (minimum 1): width of wordIndex.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  request one frame; sampled only in IDLE.
- fifoFull  in  1  UART TX FIFO full; no byte is written while high.
- wordData  in  32  snapshot word selected by wordIndex (combinational upstream mux).
- wordIndex  out  IDX_W  index of the word currently requested.
- dataToUartOutFifo  out  8  byte to the FIFO.
- writeFifoFlag  out  1  one-cycle write strobe; the byte is valid in the same cycle.
- pipeFreeze  out  1  high from start acceptance to the end of frame; drives the pipeline enable low.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse after the checksum byte is written.

## Operation
- Frame format: SOF_BYTE, NUM_WORDS[7:0], then each word 0..NUM_WORDS-1 MSB-first (4 bytes), then CHK.
  - CHK = XOR of the count byte and all payload bytes. SOF is excluded.
- States:
  - IDLE → SOF on start.
  - SOF → COUNT.
  - COUNT → LOAD.
  - LOAD: latch wordData into wordReg, set byteIdx=0 → WORD.
  - WORD: emit wordReg[31-8*byteIdx -: 8]. After byteIdx=3, go to LOAD with wordIndex+1, or to CHK if wordIndex = NUM_WORDS-1.
  - CHK → DONE.
  - DONE: pulse done → IDLE.
- SOF, COUNT, WORD and CHK each emit one byte. A state advances only on a cycle where writeFifoFlag=1, i.e. when fifoFull=0. With fifoFull=1 the state, byte, indices and checksum all hold.
- writeFifoFlag = (state ∈ {SOF, COUNT, WORD, CHK}) & ~fifoFull. Registered state, combinational strobe.
- The checksum register clears on start acceptance and XORs in each byte as it is written (COUNT, WORD).
- wordIndex resets to 0 on start acceptance and increments only on the LOAD entry that follows a completed word.
- start while busy is ignored; no queuing.
- pipeFreeze is set on start acceptance and cleared on entry to DONE.

## Timing
- Reset values: state=IDLE; wordIndex=0; dataToUartOutFifo=0; writeFifoFlag, pipeFreeze, busy, done=0; checksum=0.
- Reset asserted mid-frame aborts immediately. Bytes already written stay in the FIFO; no partial completion and no done.
- Cycle 0: start=1 in IDLE.
- Cycle 1: SOF strobe, pipeFreeze=1.
- Without backpressure, total length = 1 (SOF) + 1 (COUNT) + NUM_WORDS*5 (LOAD + 4 bytes) + 1 (CHK) + 1 (DONE) cycles. NUM_WORDS=16 gives 84 cycles, start accept to done.
- wordData must be stable from the LOAD cycle's edge. Later changes are not observed because the word is latched.
- fifoFull rising in the same cycle as a would-be write suppresses that write; the same byte is retried on the next non-full cycle.
- done and the return to IDLE coincide. A new start is accepted on the cycle after done.

## Structure
- Shared debug package holds: FRAME_SOF (8'hA5), the state enum (IDLE, SOF, COUNT, LOAD, WORD, CHK, DONE), and the NUM_WORDS value shared with the snapshot mux.
- Single module. No sub-module; the byte selector and the checksum are inline.

## Test plan
- NUM_WORDS=2, words 32'h11223344 and 32'hDEADBEEF, fifoFull=0, start pulse -> bytes A5 02 11 22 33 44 DE AD BE EF, then CHK=02^11^22^33^44^DE^AD^BE^EF; done at cycle 14; pipeFreeze high cycles 1..13.
- Same frame with fifoFull held high for 3 cycles during byte 44 -> no strobes for those 3 cycles, 44 written once, byte stream identical, done delayed by 3.
- Upstream wordData changed on the cycle after LOAD -> emitted bytes still reflect the latched value.
- start pulsed repeatedly while busy -> exactly one frame; a start on the cycle after done begins a second frame with checksum re-cleared.
- reset low during byte 3 of word 0 -> all outputs 0 asynchronously, no done; a fresh start afterwards yields a full correct frame.
- NUM_WORDS=1, word 32'h00000000 -> A5 01 00 00 00 00 01; done after 9 cycles.
